// File: rtl/dual_issue_ctrl_pkg.sv
// Shared types for the dual-issue control stage: register address width,
// issue state encoding and the per-lane control bundle.
package dual_issue_ctrl_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_SPLIT  = 1'b1
  } issue_state_e;

  // Payload width is a module parameter, so the payload is appended per module.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] a1;
    logic [REG_ADDR_W-1:0] a2;
    logic                  r1;
    logic                  r2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wr;
    logic                  ld;
  } lane_ctrl_t;

  function automatic logic wawHit(input lane_ctrl_t older, input lane_ctrl_t younger);
    return older.wr && younger.wr && (older.rd == younger.rd) && (older.rd != '0);
  endfunction

endpackage

// File: rtl/dual_issue_ctrl_if.sv
// Decode-side pair, exec-side lanes and flush/stall controls of the
// dual-issue stage. master = decode/exec environment, slave = the stage.
interface dual_issue_ctrl_if #(
  parameter int PAYLOAD_W = 64
);
  import dual_issue_ctrl_pkg::*;

  logic                  flush_i;
  logic                  ex_stall_i;
  logic                  dec_valid_i;
  logic                  dec_ready_o;
  logic                  dec_v1_i;

  logic [REG_ADDR_W-1:0] dec0_rs1_i, dec0_rs2_i, dec0_rd_i;
  logic                  dec0_r1_i, dec0_r2_i, dec0_wr_i, dec0_ld_i;
  logic [PAYLOAD_W-1:0]  dec0_pl_i;
  logic [REG_ADDR_W-1:0] dec1_rs1_i, dec1_rs2_i, dec1_rd_i;
  logic                  dec1_r1_i, dec1_r2_i, dec1_wr_i, dec1_ld_i;
  logic [PAYLOAD_W-1:0]  dec1_pl_i;

  logic                  ex0_v_o, ex0_r1_o, ex0_r2_o, ex0_wr_o, ex0_ld_o;
  logic [REG_ADDR_W-1:0] ex0_a1_o, ex0_a2_o, ex0_rd_o;
  logic [PAYLOAD_W-1:0]  ex0_pl_o;
  logic                  ex1_v_o, ex1_r1_o, ex1_r2_o, ex1_wr_o, ex1_ld_o;
  logic [REG_ADDR_W-1:0] ex1_a1_o, ex1_a2_o, ex1_rd_o;
  logic [PAYLOAD_W-1:0]  ex1_pl_o;

  modport master (
    output flush_i, ex_stall_i, dec_valid_i, dec_v1_i,
    output dec0_rs1_i, dec0_rs2_i, dec0_rd_i, dec0_r1_i, dec0_r2_i, dec0_wr_i, dec0_ld_i, dec0_pl_i,
    output dec1_rs1_i, dec1_rs2_i, dec1_rd_i, dec1_r1_i, dec1_r2_i, dec1_wr_i, dec1_ld_i, dec1_pl_i,
    input  dec_ready_o,
    input  ex0_v_o, ex0_a1_o, ex0_a2_o, ex0_r1_o, ex0_r2_o, ex0_rd_o, ex0_wr_o, ex0_ld_o, ex0_pl_o,
    input  ex1_v_o, ex1_a1_o, ex1_a2_o, ex1_r1_o, ex1_r2_o, ex1_rd_o, ex1_wr_o, ex1_ld_o, ex1_pl_o
  );

  modport slave (
    input  flush_i, ex_stall_i, dec_valid_i, dec_v1_i,
    input  dec0_rs1_i, dec0_rs2_i, dec0_rd_i, dec0_r1_i, dec0_r2_i, dec0_wr_i, dec0_ld_i, dec0_pl_i,
    input  dec1_rs1_i, dec1_rs2_i, dec1_rd_i, dec1_r1_i, dec1_r2_i, dec1_wr_i, dec1_ld_i, dec1_pl_i,
    output dec_ready_o,
    output ex0_v_o, ex0_a1_o, ex0_a2_o, ex0_r1_o, ex0_r2_o, ex0_rd_o, ex0_wr_o, ex0_ld_o, ex0_pl_o,
    output ex1_v_o, ex1_a1_o, ex1_a2_o, ex1_r1_o, ex1_r2_o, ex1_rd_o, ex1_wr_o, ex1_ld_o, ex1_pl_o
  );

endinterface

// File: rtl/dual_issue_ctrl_raw_check.sv
// Read-after-write detector: does a producer's destination feed either
// source the consumer actually reads. x0 never produces a hit.
module raw_check
  import dual_issue_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_prodRd,
  input  logic                  i_prodWr,
  input  logic [REG_ADDR_W-1:0] i_consRs1,
  input  logic                  i_consR1,
  input  logic [REG_ADDR_W-1:0] i_consRs2,
  input  logic                  i_consR2,
  output logic                  o_hit
);

  assign o_hit = i_prodWr && (i_prodRd != '0) &&
                 ((i_consR1 && (i_consRs1 == i_prodRd)) ||
                  (i_consR2 && (i_consRs2 == i_prodRd)));

endmodule

// File: rtl/dual_issue_ctrl.sv
// Dual-issue hazard control plus ID/EX pipeline register for two lanes.
// Optional issue counters are built when ISSUE_STATS_EN is defined.
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int PAYLOAD_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  dual_issue_ctrl_if.slave  bus
`ifdef ISSUE_STATS_EN
  ,
  output logic [31:0]       stat_dual_o,
  output logic [31:0]       stat_single_o,
  output logic [31:0]       stat_bubble_o
`endif
);

  typedef struct packed {
    lane_ctrl_t           c;
    logic [PAYLOAD_W-1:0] pl;
  } lane_t;

  issue_state_e r_state;
  lane_t        r_held;
  lane_t        r_ex [2];
  logic [1:0]   r_exV;

  lane_t        w_dec [2];
  lane_t        w_cand [2];
  logic [1:0]   w_candV;
  logic         w_intraHit;
  logic         w_pairConflict;
  logic [3:0]   w_luHit;
  logic         w_loadUse;

  always_comb begin
    w_dec[0].c.a1 = bus.dec0_rs1_i;
    w_dec[0].c.a2 = bus.dec0_rs2_i;
    w_dec[0].c.r1 = bus.dec0_r1_i;
    w_dec[0].c.r2 = bus.dec0_r2_i;
    w_dec[0].c.rd = bus.dec0_rd_i;
    w_dec[0].c.wr = bus.dec0_wr_i;
    w_dec[0].c.ld = bus.dec0_ld_i;
    w_dec[0].pl   = bus.dec0_pl_i;
    w_dec[1].c.a1 = bus.dec1_rs1_i;
    w_dec[1].c.a2 = bus.dec1_rs2_i;
    w_dec[1].c.r1 = bus.dec1_r1_i;
    w_dec[1].c.r2 = bus.dec1_r2_i;
    w_dec[1].c.rd = bus.dec1_rd_i;
    w_dec[1].c.wr = bus.dec1_wr_i;
    w_dec[1].c.ld = bus.dec1_ld_i;
    w_dec[1].pl   = bus.dec1_pl_i;
  end

  raw_check u_rawPair (
    .i_prodRd  (w_dec[0].c.rd),
    .i_prodWr  (w_dec[0].c.wr),
    .i_consRs1 (w_dec[1].c.a1),
    .i_consR1  (w_dec[1].c.r1),
    .i_consRs2 (w_dec[1].c.a2),
    .i_consR2  (w_dec[1].c.r2),
    .o_hit     (w_intraHit)
  );

  assign w_pairConflict = bus.dec_v1_i && (w_intraHit || wawHit(w_dec[0].c, w_dec[1].c));

  // Candidates are zeroed when not issuing so read-enables never leak from a dead lane.
  always_comb begin
    w_cand[0] = '0;
    w_cand[1] = '0;
    w_candV   = 2'b00;
    if (r_state == ST_SPLIT) begin
      w_cand[0]  = r_held;
      w_candV[0] = 1'b1;
    end else if (bus.dec_valid_i) begin
      w_cand[0]  = w_dec[0];
      w_candV[0] = 1'b1;
      if (bus.dec_v1_i && !w_pairConflict) begin
        w_cand[1]  = w_dec[1];
        w_candV[1] = 1'b1;
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_prod
    for (genvar c = 0; c < 2; c++) begin : g_cons
      raw_check u_loadUse (
        .i_prodRd  (r_ex[p].c.rd),
        .i_prodWr  (r_exV[p] && r_ex[p].c.wr && r_ex[p].c.ld),
        .i_consRs1 (w_cand[c].c.a1),
        .i_consR1  (w_cand[c].c.r1),
        .i_consRs2 (w_cand[c].c.a2),
        .i_consR2  (w_cand[c].c.r2),
        .o_hit     (w_luHit[p*2+c])
      );
    end
  end

  assign w_loadUse = |w_luHit;

  assign bus.dec_ready_o = !rst_i && !bus.ex_stall_i && !bus.flush_i &&
                           (r_state == ST_NORMAL) && !w_loadUse;

  // Flush beats stall; a load-use bubble keeps both the state and any held instruction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_NORMAL;
      r_held  <= '0;
      r_ex[0] <= '0;
      r_ex[1] <= '0;
      r_exV   <= 2'b00;
    end else if (bus.flush_i) begin
      r_state <= ST_NORMAL;
      r_held  <= '0;
      r_ex[0] <= '0;
      r_ex[1] <= '0;
      r_exV   <= 2'b00;
    end else if (!bus.ex_stall_i) begin
      if (w_loadUse) begin
        r_ex[0] <= '0;
        r_ex[1] <= '0;
        r_exV   <= 2'b00;
      end else begin
        r_ex[0] <= w_cand[0];
        r_ex[1] <= w_cand[1];
        r_exV   <= w_candV;
        if (r_state == ST_SPLIT) begin
          r_state <= ST_NORMAL;
          r_held  <= '0;
        end else if (bus.dec_valid_i && w_pairConflict) begin
          r_state <= ST_SPLIT;
          r_held  <= w_dec[1];
        end
      end
    end
  end

  assign bus.ex0_v_o  = r_exV[0];
  assign bus.ex0_a1_o = r_ex[0].c.a1;
  assign bus.ex0_a2_o = r_ex[0].c.a2;
  assign bus.ex0_r1_o = r_ex[0].c.r1;
  assign bus.ex0_r2_o = r_ex[0].c.r2;
  assign bus.ex0_rd_o = r_ex[0].c.rd;
  assign bus.ex0_wr_o = r_ex[0].c.wr;
  assign bus.ex0_ld_o = r_ex[0].c.ld;
  assign bus.ex0_pl_o = r_ex[0].pl;
  assign bus.ex1_v_o  = r_exV[1];
  assign bus.ex1_a1_o = r_ex[1].c.a1;
  assign bus.ex1_a2_o = r_ex[1].c.a2;
  assign bus.ex1_r1_o = r_ex[1].c.r1;
  assign bus.ex1_r2_o = r_ex[1].c.r2;
  assign bus.ex1_rd_o = r_ex[1].c.rd;
  assign bus.ex1_wr_o = r_ex[1].c.wr;
  assign bus.ex1_ld_o = r_ex[1].c.ld;
  assign bus.ex1_pl_o = r_ex[1].pl;

`ifdef ISSUE_STATS_EN
  logic [1:0]  w_issuedLanes;
  logic [31:0] r_statDual, r_statSingle, r_statBubble;

  assign w_issuedLanes = (bus.flush_i || w_loadUse) ? 2'd0 :
                         ({1'b0, w_candV[0]} + {1'b0, w_candV[1]});

  // Counters saturate at all-ones and are untouched by flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_statDual   <= '0;
      r_statSingle <= '0;
      r_statBubble <= '0;
    end else if (bus.flush_i || !bus.ex_stall_i) begin
      case (w_issuedLanes)
        2'd2:    if (r_statDual   != '1) r_statDual   <= r_statDual + 32'd1;
        2'd1:    if (r_statSingle != '1) r_statSingle <= r_statSingle + 32'd1;
        default: if (r_statBubble != '1) r_statBubble <= r_statBubble + 32'd1;
      endcase
    end
  end

  assign stat_dual_o   = r_statDual;
  assign stat_single_o = r_statSingle;
  assign stat_bubble_o = r_statBubble;
`endif

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scoreboard bench for dual_issue_ctrl: directed pairs push hand-computed
// expectations, a monitor process pops and compares each cycle.
`timescale 1ns/1ps
module tb_dual_issue_ctrl;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        r1;
    logic        r2;
    logic        wr;
    logic        ld;
    logic [63:0] pl;
  } instr_t;

  typedef struct {
    int     id;
    logic   ready;
    logic   v0;
    logic   v1;
    instr_t i0;
    instr_t i1;
  } exp_t;

  logic clk;
  logic rst;
  int   assertCount = 0;
  int   failCount   = 0;
  int   stepId      = 0;
  exp_t expQ[$];

  dual_issue_ctrl_if #(.PAYLOAD_W(64)) bus ();

`ifdef ISSUE_STATS_EN
  logic [31:0] statDual, statSingle, statBubble;
`endif

  dual_issue_ctrl #(.PAYLOAD_W(64)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
`ifdef ISSUE_STATS_EN
    ,
    .stat_dual_o   (statDual),
    .stat_single_o (statSingle),
    .stat_bubble_o (statBubble)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic instr_t aluOp(input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic [7:0] tag);
    instr_t x;
    x.rd = rd; x.rs1 = rs1; x.rs2 = rs2;
    x.r1 = 1'b1; x.r2 = 1'b1; x.wr = 1'b1; x.ld = 1'b0;
    x.pl = 64'hC0DE_0000_0000_0000 | {56'd0, tag};
    return x;
  endfunction

  function automatic instr_t loadOp(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [7:0] tag);
    instr_t x;
    x.rd = rd; x.rs1 = rs1; x.rs2 = 5'd0;
    x.r1 = 1'b1; x.r2 = 1'b0; x.wr = 1'b1; x.ld = 1'b1;
    x.pl = 64'hBEEF_0000_0000_0000 | {56'd0, tag};
    return x;
  endfunction

  function automatic instr_t noOp();
    instr_t x;
    x.rd = 5'd0; x.rs1 = 5'd0; x.rs2 = 5'd0;
    x.r1 = 1'b0; x.r2 = 1'b0; x.wr = 1'b0; x.ld = 1'b0;
    x.pl = 64'd0;
    return x;
  endfunction

  function automatic exp_t mkExp(input logic ready, input logic v0, input instr_t i0,
                                 input logic v1, input instr_t i1);
    exp_t e;
    e.id = 0; e.ready = ready;
    e.v0 = v0; e.i0 = v0 ? i0 : noOp();
    e.v1 = v1; e.i1 = v1 ? i1 : noOp();
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkLane(input int id, input int lane, input logic expV, input instr_t e);
    logic v, r1, r2, wr, ld;
    logic [4:0] a1, a2, rd;
    logic [63:0] pl;
    if (lane == 0) begin
      v = bus.ex0_v_o; r1 = bus.ex0_r1_o; r2 = bus.ex0_r2_o; wr = bus.ex0_wr_o; ld = bus.ex0_ld_o;
      a1 = bus.ex0_a1_o; a2 = bus.ex0_a2_o; rd = bus.ex0_rd_o; pl = bus.ex0_pl_o;
    end else begin
      v = bus.ex1_v_o; r1 = bus.ex1_r1_o; r2 = bus.ex1_r2_o; wr = bus.ex1_wr_o; ld = bus.ex1_ld_o;
      a1 = bus.ex1_a1_o; a2 = bus.ex1_a2_o; rd = bus.ex1_rd_o; pl = bus.ex1_pl_o;
    end
    checkOutput($sformatf("s%0d.ex%0d.v", id, lane), {63'd0, v}, {63'd0, expV});
    checkOutput($sformatf("s%0d.ex%0d.r1", id, lane), {63'd0, r1}, {63'd0, e.r1});
    checkOutput($sformatf("s%0d.ex%0d.r2", id, lane), {63'd0, r2}, {63'd0, e.r2});
    checkOutput($sformatf("s%0d.ex%0d.wr", id, lane), {63'd0, wr}, {63'd0, e.wr});
    checkOutput($sformatf("s%0d.ex%0d.ld", id, lane), {63'd0, ld}, {63'd0, e.ld});
    if (expV) begin
      checkOutput($sformatf("s%0d.ex%0d.a1", id, lane), {59'd0, a1}, {59'd0, e.rs1});
      checkOutput($sformatf("s%0d.ex%0d.a2", id, lane), {59'd0, a2}, {59'd0, e.rs2});
      checkOutput($sformatf("s%0d.ex%0d.rd", id, lane), {59'd0, rd}, {59'd0, e.rd});
      checkOutput($sformatf("s%0d.ex%0d.pl", id, lane), pl, e.pl);
    end
  endtask

  task automatic driveInputs(input logic valid, input logic v1, input instr_t i0,
                             input instr_t i1, input logic flush, input logic stall);
    bus.dec_valid_i = valid; bus.dec_v1_i = v1;
    bus.flush_i = flush; bus.ex_stall_i = stall;
    bus.dec0_rs1_i = i0.rs1; bus.dec0_rs2_i = i0.rs2; bus.dec0_rd_i = i0.rd;
    bus.dec0_r1_i = i0.r1; bus.dec0_r2_i = i0.r2; bus.dec0_wr_i = i0.wr;
    bus.dec0_ld_i = i0.ld; bus.dec0_pl_i = i0.pl;
    bus.dec1_rs1_i = i1.rs1; bus.dec1_rs2_i = i1.rs2; bus.dec1_rd_i = i1.rd;
    bus.dec1_r1_i = i1.r1; bus.dec1_r2_i = i1.r2; bus.dec1_wr_i = i1.wr;
    bus.dec1_ld_i = i1.ld; bus.dec1_pl_i = i1.pl;
  endtask

  task automatic applyStimulus(input logic valid, input logic v1, input instr_t i0,
                               input instr_t i1, input logic flush, input logic stall,
                               input exp_t e);
    @(negedge clk);
    stepId++;
    e.id = stepId;
    expQ.push_back(e);
    driveInputs(valid, v1, i0, i1, flush, stall);
  endtask

  // Monitor: ready is sampled before the edge, ex lanes just after it.
  initial begin
    exp_t cur;
    forever begin
      @(negedge clk);
      #2;
      if (expQ.size() > 0) begin
        cur = expQ.pop_front();
        checkOutput($sformatf("s%0d.ready", cur.id), {63'd0, bus.dec_ready_o}, {63'd0, cur.ready});
        @(posedge clk);
        #1;
        checkLane(cur.id, 0, cur.v0, cur.i0);
        checkLane(cur.id, 1, cur.v1, cur.i1);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    instr_t nop, iA, iB, iC, iD, iE, iF, iG, iH, iL, iM, iN, iO, iP, iQ, iR, iS;
    instr_t iT, iU, iV, iW, iX, iY, iZ1, iZ2, iZ3, iZ4, iK1, iK2, iJ1, iJ2;
    nop = noOp();
    iA  = aluOp(5'd1, 5'd10, 5'd11, 8'd1);   iB  = aluOp(5'd2, 5'd12, 5'd13, 8'd2);
    iC  = aluOp(5'd3, 5'd14, 5'd15, 8'd3);   iD  = aluOp(5'd9, 5'd16, 5'd17, 8'd4);
    iE  = aluOp(5'd5, 5'd1, 5'd2, 8'd5);     iF  = aluOp(5'd6, 5'd5, 5'd3, 8'd6);
    iG  = aluOp(5'd20, 5'd21, 5'd22, 8'd7);  iH  = aluOp(5'd23, 5'd24, 5'd25, 8'd8);
    iL  = loadOp(5'd7, 5'd1, 8'd9);          iM  = aluOp(5'd8, 5'd7, 5'd1, 8'd10);
    iN  = loadOp(5'd0, 5'd1, 8'd11);         iO  = aluOp(5'd8, 5'd0, 5'd1, 8'd12);
    iP  = aluOp(5'd4, 5'd1, 5'd2, 8'd13);    iQ  = aluOp(5'd4, 5'd3, 5'd9, 8'd14);
    iR  = aluOp(5'd0, 5'd1, 5'd2, 8'd15);    iS  = aluOp(5'd0, 5'd3, 5'd9, 8'd16);
    iT  = aluOp(5'd5, 5'd1, 5'd2, 8'd17);    iU  = aluOp(5'd6, 5'd5, 5'd3, 8'd18);
    iV  = aluOp(5'd10, 5'd1, 5'd2, 8'd19);   iW  = aluOp(5'd11, 5'd3, 5'd4, 8'd20);
    iX  = aluOp(5'd1, 5'd2, 5'd3, 8'd21);    iY  = aluOp(5'd2, 5'd1, 5'd4, 8'd22);
    iZ1 = aluOp(5'd15, 5'd1, 5'd2, 8'd23);   iZ2 = aluOp(5'd16, 5'd3, 5'd4, 8'd24);
    iZ3 = aluOp(5'd17, 5'd5, 5'd6, 8'd25);   iZ4 = aluOp(5'd18, 5'd7, 5'd8, 8'd26);
    iK1 = aluOp(5'd26, 5'd1, 5'd2, 8'd27);   iK2 = loadOp(5'd12, 5'd3, 8'd28);
    iJ1 = aluOp(5'd13, 5'd14, 5'd15, 8'd29); iJ2 = aluOp(5'd27, 5'd12, 5'd1, 8'd30);

    rst = 1'b1;
    driveInputs(1'b0, 1'b0, nop, nop, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset.ready", {63'd0, bus.dec_ready_o}, 64'd0);
    checkOutput("reset.ex0.v", {63'd0, bus.ex0_v_o}, 64'd0);
    checkOutput("reset.ex1.v", {63'd0, bus.ex1_v_o}, 64'd0);
    checkOutput("reset.ex0.pl", bus.ex0_pl_o, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] independent pairs");
    applyStimulus(1, 1, iA, iB, 0, 0, mkExp(1, 1, iA, 1, iB));
    applyStimulus(1, 1, iC, iD, 0, 0, mkExp(1, 1, iC, 1, iD));
    $display("[TB] intra-pair RAW split");
    applyStimulus(1, 1, iE, iF, 0, 0, mkExp(1, 1, iE, 0, nop));
    applyStimulus(1, 1, iG, iH, 0, 0, mkExp(0, 1, iF, 0, nop));
    applyStimulus(1, 1, iG, iH, 0, 0, mkExp(1, 1, iG, 1, iH));
    $display("[TB] load-use and x0 load");
    applyStimulus(1, 0, iL, nop, 0, 0, mkExp(1, 1, iL, 0, nop));
    applyStimulus(1, 0, iM, nop, 0, 0, mkExp(0, 0, nop, 0, nop));
    applyStimulus(1, 0, iM, nop, 0, 0, mkExp(1, 1, iM, 0, nop));
    applyStimulus(1, 0, iN, nop, 0, 0, mkExp(1, 1, iN, 0, nop));
    applyStimulus(1, 0, iO, nop, 0, 0, mkExp(1, 1, iO, 0, nop));
    $display("[TB] WAW split and x0 WAW");
    applyStimulus(1, 1, iP, iQ, 0, 0, mkExp(1, 1, iP, 0, nop));
    applyStimulus(0, 0, nop, nop, 0, 0, mkExp(0, 1, iQ, 0, nop));
    applyStimulus(0, 0, nop, nop, 0, 0, mkExp(1, 0, nop, 0, nop));
    applyStimulus(1, 1, iR, iS, 0, 0, mkExp(1, 1, iR, 1, iS));
    $display("[TB] flush in split, flush with stall");
    applyStimulus(1, 1, iT, iU, 0, 0, mkExp(1, 1, iT, 0, nop));
    applyStimulus(1, 1, iV, iW, 1, 0, mkExp(0, 0, nop, 0, nop));
    applyStimulus(1, 1, iV, iW, 0, 0, mkExp(1, 1, iV, 1, iW));
    applyStimulus(1, 1, iX, iY, 1, 1, mkExp(0, 0, nop, 0, nop));
    $display("[TB] exec stall hold");
    applyStimulus(1, 1, iZ1, iZ2, 0, 0, mkExp(1, 1, iZ1, 1, iZ2));
    for (int k = 0; k < 3; k++)
      applyStimulus(1, 1, iZ3, iZ4, 0, 1, mkExp(0, 1, iZ1, 1, iZ2));
    applyStimulus(1, 1, iZ3, iZ4, 0, 0, mkExp(1, 1, iZ3, 1, iZ4));
    $display("[TB] load-use from lane 1");
    applyStimulus(1, 1, iK1, iK2, 0, 0, mkExp(1, 1, iK1, 1, iK2));
    applyStimulus(1, 1, iJ1, iJ2, 0, 0, mkExp(0, 0, nop, 0, nop));
    applyStimulus(1, 1, iJ1, iJ2, 0, 0, mkExp(1, 1, iJ1, 1, iJ2));

    $display("[TB] asynchronous reset mid-run");
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("asyncRst.ex0.v", {63'd0, bus.ex0_v_o}, 64'd0);
    checkOutput("asyncRst.ex1.v", {63'd0, bus.ex1_v_o}, 64'd0);
    checkOutput("asyncRst.ex0.pl", bus.ex0_pl_o, 64'd0);
    checkOutput("asyncRst.ex1.rd", {59'd0, bus.ex1_rd_o}, 64'd0);
    checkOutput("asyncRst.ready", {63'd0, bus.dec_ready_o}, 64'd0);
    driveInputs(1'b0, 1'b0, nop, nop, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1, 1, iA, iB, 0, 0, mkExp(1, 1, iA, 1, iB));
    @(negedge clk);
    driveInputs(1'b0, 1'b0, nop, nop, 1'b0, 1'b0);
    @(posedge clk);
    #3;

    for (int k = 0; k < 10 && expQ.size() != 0; k++) @(posedge clk);
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
